// File: rtl/wm_timer_pkg.sv
// Shared types and constants for the washing-machine phase timer.
// Phase, program and state encodings plus duration scaling.
package wm_timer_pkg;

  typedef enum logic [2:0] {
    PH_NONE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_HEAT  = 3'd2,
    PH_WASH  = 3'd3,
    PH_RINSE = 3'd4,
    PH_SPIN  = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    PROG_NORMAL  = 2'd0,
    PROG_QUICK   = 2'd1,
    PROG_HEAVY   = 2'd2,
    PROG_NORMAL3 = 2'd3
  } prog_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam logic [15:0] DEF_FILL_TIME  = 16'd120;
  localparam logic [15:0] DEF_HEAT_TIME  = 16'd300;
  localparam logic [15:0] DEF_WASH_TIME  = 16'd600;
  localparam logic [15:0] DEF_RINSE_TIME = 16'd240;
  localparam logic [15:0] DEF_SPIN_TIME  = 16'd180;

  // Heavy sums in 17 bits so overflow saturates; a zero result would never expire, so it becomes 1.
  function automatic logic [15:0] scale_duration(input logic [15:0] d, input prog_e p);
    logic [16:0] s;
    case (p)
      PROG_QUICK: s = {2'b00, d[15:1]};
      PROG_HEAVY: s = {1'b0, d} + {2'b00, d[15:1]};
      default:    s = {1'b0, d};
    endcase
    if (s[16]) begin
      return 16'hFFFF;
    end
    if (s[15:0] == 16'd0) begin
      return 16'd1;
    end
    return s[15:0];
  endfunction

endpackage

// File: rtl/wm_down_counter.sv
// Loadable down counter; zero_reached strobes on the enabled 1 -> 0 step.
module wm_down_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         zero_reached
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count        = count_q;
  assign zero_reached = enable && !load && (count_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/wm_phase_timer.sv
// Phase watchdog/duration timer: decodes the active controller phase, loads a
// program-scaled duration on phase entry and pulses the matching completion output.
module wm_phase_timer
  import wm_timer_pkg::*;
#(
  parameter logic [15:0] FILL_TIME  = DEF_FILL_TIME,
  parameter logic [15:0] HEAT_TIME  = DEF_HEAT_TIME,
  parameter logic [15:0] WASH_TIME  = DEF_WASH_TIME,
  parameter logic [15:0] RINSE_TIME = DEF_RINSE_TIME,
  parameter logic [15:0] SPIN_TIME  = DEF_SPIN_TIME
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        pause,
  input  logic [1:0]  program_Select,
  input  logic        fill_Water_Operation,
  input  logic        heat_Water_Operation,
  input  logic        wash_Operation,
  input  logic        rinse_Operation,
  input  logic        spin_Operation,
  output logic        sig_Time_Out,
  output logic        sig_Wash_Completed,
  output logic        sig_Rinse_Completed,
  output logic        sig_Spin_Completed,
  output logic [15:0] remaining,
  output logic        phase_Error
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  prog_e       prog_q, prog_d;
  logic        time_out_q, time_out_d;
  logic        wash_done_q, wash_done_d;
  logic        rinse_done_q, rinse_done_d;
  logic        spin_done_q, spin_done_d;
  logic        phase_error_q, phase_error_d;

  logic [4:0]  ops;
  phase_e      dec_phase;
  logic [15:0] base_dur;
  prog_e       prog_eff;
  logic        cnt_load;
  logic [15:0] cnt_value;
  logic        cnt_en;
  logic        cnt_zero;
  logic [15:0] cnt_count;

  always_comb begin
    ops           = {fill_Water_Operation, heat_Water_Operation, wash_Operation,
                     rinse_Operation, spin_Operation};
    phase_error_d = |(ops & (ops - 5'd1));
    case (ops)
      5'b10000: dec_phase = PH_FILL;
      5'b01000: dec_phase = PH_HEAT;
      5'b00100: dec_phase = PH_WASH;
      5'b00010: dec_phase = PH_RINSE;
      5'b00001: dec_phase = PH_SPIN;
      default:  dec_phase = PH_NONE;
    endcase
  end

  always_comb begin
    case (dec_phase)
      PH_FILL:  base_dur = FILL_TIME;
      PH_HEAT:  base_dur = HEAT_TIME;
      PH_WASH:  base_dur = WASH_TIME;
      PH_RINSE: base_dur = RINSE_TIME;
      PH_SPIN:  base_dur = SPIN_TIME;
      default:  base_dur = 16'd0;
    endcase
    // A fresh run from IDLE samples the selector; phase-to-phase moves keep the latched program.
    prog_eff = (state_q == ST_IDLE) ? prog_e'(program_Select) : prog_q;
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = dec_phase;
    prog_d       = prog_q;
    time_out_d   = 1'b0;
    wash_done_d  = 1'b0;
    rinse_done_d = 1'b0;
    spin_done_d  = 1'b0;
    cnt_load     = 1'b0;
    cnt_value    = scale_duration(base_dur, prog_eff);
    if (dec_phase == PH_NONE) begin
      state_d   = ST_IDLE;
      cnt_load  = 1'b1;
      cnt_value = 16'd0;
    end else if (dec_phase != phase_q) begin
      state_d  = ST_RUN;
      cnt_load = 1'b1;
      if (state_q == ST_IDLE) begin
        prog_d = prog_e'(program_Select);
      end
    end else if ((state_q == ST_RUN) && cnt_zero) begin
      state_d = ST_EXPIRED;
      case (phase_q)
        PH_FILL, PH_HEAT: time_out_d   = 1'b1;
        PH_WASH:          wash_done_d  = 1'b1;
        PH_RINSE:         rinse_done_d = 1'b1;
        PH_SPIN:          spin_done_d  = 1'b1;
        default:          ;
      endcase
    end
  end

  assign cnt_en = (state_q == ST_RUN) && tick && !pause;

  wm_down_counter #(
    .W(16)
  ) u_counter (
    .clock       (clock),
    .reset       (reset),
    .load        (cnt_load),
    .load_value  (cnt_value),
    .enable      (cnt_en),
    .count       (cnt_count),
    .zero_reached(cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_NONE;
      prog_q        <= PROG_NORMAL;
      time_out_q    <= 1'b0;
      wash_done_q   <= 1'b0;
      rinse_done_q  <= 1'b0;
      spin_done_q   <= 1'b0;
      phase_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      prog_q        <= prog_d;
      time_out_q    <= time_out_d;
      wash_done_q   <= wash_done_d;
      rinse_done_q  <= rinse_done_d;
      spin_done_q   <= spin_done_d;
      phase_error_q <= phase_error_d;
    end
  end

  assign sig_Time_Out        = time_out_q;
  assign sig_Wash_Completed  = wash_done_q;
  assign sig_Rinse_Completed = rinse_done_q;
  assign sig_Spin_Completed  = spin_done_q;
  assign remaining           = cnt_count;
  assign phase_Error         = phase_error_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: each task drives one scenario and checks
// remaining/pulses/phase_Error against hand-computed values.
module tb_wm_phase_timer;

  logic        clock = 1'b0;
  logic        reset;
  logic        tick;
  logic        pause;
  logic [1:0]  program_Select;
  logic        fill_Water_Operation, heat_Water_Operation, wash_Operation;
  logic        rinse_Operation, spin_Operation;
  logic        sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed;
  logic [15:0] remaining;
  logic        phase_Error;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [4:0] OP_FILL  = 5'b10000;
  localparam logic [4:0] OP_HEAT  = 5'b01000;
  localparam logic [4:0] OP_WASH  = 5'b00100;
  localparam logic [4:0] OP_RINSE = 5'b00010;
  localparam logic [4:0] OP_SPIN  = 5'b00001;

  // Pulse vector order: {time_out, wash, rinse, spin}
  localparam logic [3:0] P_NONE  = 4'b0000;
  localparam logic [3:0] P_TO    = 4'b1000;
  localparam logic [3:0] P_WASH  = 4'b0100;
  localparam logic [3:0] P_RINSE = 4'b0010;
  localparam logic [3:0] P_SPIN  = 4'b0001;

  logic [3:0] pulses;
  assign pulses = {sig_Time_Out, sig_Wash_Completed, sig_Rinse_Completed, sig_Spin_Completed};

  always #5 clock = ~clock;

  wm_phase_timer #(
    .FILL_TIME (16'd10),
    .HEAT_TIME (16'd6),
    .WASH_TIME (16'd4),
    .RINSE_TIME(16'd1),
    .SPIN_TIME (16'hC000)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .tick                (tick),
    .pause               (pause),
    .program_Select      (program_Select),
    .fill_Water_Operation(fill_Water_Operation),
    .heat_Water_Operation(heat_Water_Operation),
    .wash_Operation      (wash_Operation),
    .rinse_Operation     (rinse_Operation),
    .spin_Operation      (spin_Operation),
    .sig_Time_Out        (sig_Time_Out),
    .sig_Wash_Completed  (sig_Wash_Completed),
    .sig_Rinse_Completed (sig_Rinse_Completed),
    .sig_Spin_Completed  (sig_Spin_Completed),
    .remaining           (remaining),
    .phase_Error         (phase_Error)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input logic [4:0] v);
    {fill_Water_Operation, heat_Water_Operation, wash_Operation,
     rinse_Operation, spin_Operation} = v;
  endtask

  task automatic go_idle();
    set_ops(5'b00000);
    pause = 1'b0;
    step();
    step();
  endtask

  // Steps until any pulse is visible; n = edges after the load edge (100 = never seen).
  task automatic run_until_pulse(output int n);
    n = 100;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (pulses != 4'b0000) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ops(OP_WASH);
    step();
    step();
    total_cnt++;
    if (remaining !== 16'd0) $display("FAIL reset_rem got %0d want 0", remaining);
    else pass_cnt++;
    total_cnt++;
    if (pulses !== P_NONE) $display("FAIL reset_pulses got %b want %b", pulses, P_NONE);
    else pass_cnt++;
    total_cnt++;
    if (phase_Error !== 1'b0) $display("FAIL reset_err got %b want 0", phase_Error);
    else pass_cnt++;
    set_ops(5'b00000);
    @(negedge clock);
    reset = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_wash_normal();
    int n;
    logic [15:0] exp_rem;
    logic [3:0]  exp_p;
    program_Select = 2'd0;
    tick = 1'b1;
    set_ops(OP_WASH);
    for (int i = 0; i < 5; i++) begin
      step();
      exp_rem = 16'd4 - 16'(i);
      exp_p   = (i == 4) ? P_WASH : P_NONE;
      total_cnt++;
      if (remaining !== exp_rem) $display("FAIL wash_rem cyc=%0d got %0d want %0d", i, remaining, exp_rem);
      else pass_cnt++;
      total_cnt++;
      if (pulses !== exp_p) $display("FAIL wash_pulse cyc=%0d got %b want %b", i, pulses, exp_p);
      else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (remaining !== 16'd0 || pulses !== P_NONE)
        $display("FAIL wash_expired_hold got rem=%0d p=%b want rem=0 p=0000", remaining, pulses);
      else pass_cnt++;
    end
    go_idle();
    program_Select = 2'd2;
    set_ops(OP_WASH);
    step();
    total_cnt++;
    if (remaining !== 16'd6) $display("FAIL wash_heavy_load got %0d want 6", remaining);
    else pass_cnt++;
    run_until_pulse(n);
    total_cnt++;
    if (n !== 6 || pulses !== P_WASH) $display("FAIL wash_heavy_lat got n=%0d p=%b want n=6 p=%b", n, pulses, P_WASH);
    else pass_cnt++;
    go_idle();
    $display("test_wash_normal done");
  endtask

  task automatic test_quick_pause();
    int n;
    program_Select = 2'd1;
    tick = 1'b1;
    set_ops(OP_FILL);
    step();
    total_cnt++;
    if (remaining !== 16'd5) $display("FAIL fill_quick_load got %0d want 5", remaining);
    else pass_cnt++;
    run_until_pulse(n);
    total_cnt++;
    if (n !== 5 || pulses !== P_TO) $display("FAIL fill_unpaused_lat got n=%0d p=%b want n=5 p=%b", n, pulses, P_TO);
    else pass_cnt++;
    go_idle();
    set_ops(OP_FILL);
    step();
    step();
    step();
    pause = 1'b1;
    repeat (3) step();
    total_cnt++;
    if (remaining !== 16'd3 || pulses !== P_NONE)
      $display("FAIL fill_pause_hold got rem=%0d p=%b want rem=3 p=0000", remaining, pulses);
    else pass_cnt++;
    pause = 1'b0;
    run_until_pulse(n);
    total_cnt++;
    if (n !== 3 || pulses !== P_TO) $display("FAIL fill_paused_lat got n=%0d p=%b want n=3 p=%b", n, pulses, P_TO);
    else pass_cnt++;
    go_idle();
    set_ops(OP_FILL);
    step();
    step();
    program_Select = 2'd2;
    set_ops(OP_HEAT);
    step();
    total_cnt++;
    if (remaining !== 16'd3) $display("FAIL prog_latch_heat got %0d want 3", remaining);
    else pass_cnt++;
    run_until_pulse(n);
    total_cnt++;
    if (n !== 3 || pulses !== P_TO) $display("FAIL prog_latch_lat got n=%0d p=%b want n=3 p=%b", n, pulses, P_TO);
    else pass_cnt++;
    go_idle();
    $display("test_quick_pause done");
  endtask

  task automatic test_scaling();
    program_Select = 2'd2;
    tick = 1'b1;
    set_ops(OP_SPIN);
    step();
    total_cnt++;
    if (remaining !== 16'hFFFF) $display("FAIL spin_saturate got %h want ffff", remaining);
    else pass_cnt++;
    step();
    total_cnt++;
    if (remaining !== 16'hFFFE) $display("FAIL spin_decrement got %h want fffe", remaining);
    else pass_cnt++;
    go_idle();
    program_Select = 2'd1;
    set_ops(OP_RINSE);
    step();
    total_cnt++;
    if (remaining !== 16'd1) $display("FAIL rinse_clamp got %0d want 1", remaining);
    else pass_cnt++;
    step();
    total_cnt++;
    if (remaining !== 16'd0 || pulses !== P_RINSE)
      $display("FAIL rinse_clamp_pulse got rem=%0d p=%b want rem=0 p=%b", remaining, pulses, P_RINSE);
    else pass_cnt++;
    step();
    total_cnt++;
    if (pulses !== P_NONE) $display("FAIL rinse_single_pulse got %b want 0000", pulses);
    else pass_cnt++;
    go_idle();
    $display("test_scaling done");
  endtask

  task automatic test_phase_error();
    program_Select = 2'd0;
    tick = 1'b1;
    set_ops(OP_WASH);
    step();
    step();
    set_ops(OP_WASH | OP_RINSE);
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (phase_Error !== 1'b1 || remaining !== 16'd0 || pulses !== P_NONE)
        $display("FAIL err_multi cyc=%0d got err=%b rem=%0d p=%b want err=1 rem=0 p=0000",
                 i, phase_Error, remaining, pulses);
      else pass_cnt++;
    end
    set_ops(OP_RINSE);
    step();
    total_cnt++;
    if (phase_Error !== 1'b0 || remaining !== 16'd1)
      $display("FAIL err_recover got err=%b rem=%0d want err=0 rem=1", phase_Error, remaining);
    else pass_cnt++;
    step();
    total_cnt++;
    if (pulses !== P_RINSE) $display("FAIL err_recover_pulse got %b want %b", pulses, P_RINSE);
    else pass_cnt++;
    go_idle();
    $display("test_phase_error done");
  endtask

  task automatic test_reset_midcount();
    int n;
    program_Select = 2'd0;
    tick = 1'b1;
    set_ops(OP_HEAT);
    step();
    total_cnt++;
    if (remaining !== 16'd6) $display("FAIL heat_load got %0d want 6", remaining);
    else pass_cnt++;
    repeat (4) step();
    total_cnt++;
    if (remaining !== 16'd2) $display("FAIL heat_mid got %0d want 2", remaining);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (remaining !== 16'd0 || pulses !== P_NONE)
      $display("FAIL async_reset got rem=%0d p=%b want rem=0 p=0000", remaining, pulses);
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    step();
    total_cnt++;
    if (remaining !== 16'd6) $display("FAIL heat_reload got %0d want 6", remaining);
    else pass_cnt++;
    run_until_pulse(n);
    total_cnt++;
    if (n !== 6 || pulses !== P_TO) $display("FAIL heat_reload_lat got n=%0d p=%b want n=6 p=%b", n, pulses, P_TO);
    else pass_cnt++;
    go_idle();
    $display("test_reset_midcount done");
  endtask

  initial begin
    reset          = 1'b1;
    tick           = 1'b0;
    pause          = 1'b0;
    program_Select = 2'd0;
    set_ops(5'b00000);
    test_reset();
    test_wash_normal();
    test_quick_pause();
    test_scaling();
    test_phase_error();
    test_reset_midcount();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "bench timeout");
  end

endmodule
